pipe_phy_loopback_model: RTL and testbench

Synthesizable PIPE PHY stand-in that sits directly downstream of the `PCIe` controller's PIPE interface, replacing the hand-coded stimulus and `assign` loopback currently in the system bench. It loops Tx back to Rx through a configurable pipeline and answers receiver-detect, PowerDown and Rate requests with correctly timed `PhyStatus`/`RxStatus` handshakes. This lets the LTSSM reach `linkUp` without scripted timing.

---
 rtl/pipe_phy_loopback_model.sv | 218 +++++++++++++++++++++
 tb/tb_pipe_phy_loopback_model.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_phy_loopback_model.sv
// PIPE PHY stand-in: loops Tx back to Rx and answers detect / PowerDown / Rate requests with PhyStatus.
// Define PIPE_PHY_ERR_INJECT_EN to add the ErrInject port for lane-0 decode-error injection.
module pipe_phy_loopback_model #(
   parameter int unsigned LANESNUMBER  = 16,
   parameter int unsigned MAXPIPEWIDTH = 32,
   parameter int unsigned LOOP_LATENCY = 2,
   parameter int unsigned DETECT_DELAY = 4,
   parameter int unsigned CHANGE_DELAY = 3
) (
   input  logic                                    CLK,
   input  logic                                    reset,
   input  logic [MAXPIPEWIDTH*LANESNUMBER-1:0]     TxData,
   input  logic [(MAXPIPEWIDTH/8)*LANESNUMBER-1:0] TxDataK,
   input  logic [LANESNUMBER-1:0]                  TxDataValid,
   input  logic [LANESNUMBER-1:0]                  TxElecIdle,
   input  logic [LANESNUMBER-1:0]                  TxDetectRx_Loopback,
   input  logic [4*LANESNUMBER-1:0]                PowerDown,
   input  logic [3:0]                              Rate,
   input  logic [LANESNUMBER-1:0]                  LanePresent,
`ifdef PIPE_PHY_ERR_INJECT_EN
   input  logic                                    ErrInject,
`endif
   output logic [MAXPIPEWIDTH*LANESNUMBER-1:0]     RxData,
   output logic [(MAXPIPEWIDTH/8)*LANESNUMBER-1:0] RxDataK,
   output logic [LANESNUMBER-1:0]                  RxDataValid,
   output logic [LANESNUMBER-1:0]                  RxValid,
   output logic [LANESNUMBER-1:0]                  RxElectricalIdle,
   output logic [3*LANESNUMBER-1:0]                RxStatus,
   output logic [LANESNUMBER-1:0]                  PhyStatus
);

   localparam int unsigned KW   = MAXPIPEWIDTH / 8;
   localparam int unsigned DW   = MAXPIPEWIDTH * LANESNUMBER;
   localparam int unsigned KTW  = KW * LANESNUMBER;
   localparam int unsigned STW  = 1 + 2 * LANESNUMBER + KTW + DW;
   localparam int unsigned MAXD = (DETECT_DELAY > CHANGE_DELAY) ? DETECT_DELAY : CHANGE_DELAY;
   localparam int unsigned CW   = (MAXD > 1) ? $clog2(MAXD) : 1;

   localparam logic [3:0] PD_P0 = 4'b0000;
   localparam logic [3:0] PD_P1 = 4'b0010;
   // Pipeline stage layout {err, elec_idle, valid, k, data}; idle resets high
   localparam logic [STW-1:0] STAGE_RST = {1'b0, {LANESNUMBER{1'b1}}, {(LANESNUMBER + KTW + DW){1'b0}}};

   typedef enum logic [2:0] {RST_HOLD, IDLE, DETECT, DET_DONE, CHANGE} state_t;

   state_t         state;
   logic           hold_cnt;
   logic           fire;
   logic [CW-1:0]  cnt;
   logic [3:0]     sh_rate, sh_pd, tgt_rate, tgt_pd;
   logic           det_req, chg_req;
   logic           err_in;
   logic [DW-1:0]  data_in;
   logic [STW-1:0] tx_in, tail;
   logic [STW-1:0] stage [LOOP_LATENCY];
   logic           unused_pd;

   logic [DW-1:0]            t_data, data_mask;
   logic [KTW-1:0]           t_k, k_mask;
   logic [LANESNUMBER-1:0]   t_valid, t_idle, lane_on, eidle;
   logic                     t_err;
   logic [3*LANESNUMBER-1:0] det_status;

   assign unused_pd = ^PowerDown[4*LANESNUMBER-1:4];

   // Detect qualifies on the PHY's current (shadow) power state, so a PowerDown
   // change arriving with the request is serviced after detection completes.
   assign det_req = (|TxDetectRx_Loopback) && (sh_pd == PD_P1) && TxElecIdle[0];
   assign chg_req = (Rate != sh_rate) || (PowerDown[3:0] != sh_pd);

`ifdef PIPE_PHY_ERR_INJECT_EN
   assign err_in = ErrInject && (state == IDLE);
`else
   assign err_in = 1'b0;
`endif

   always_comb begin
      data_in    = TxData;
      data_in[0] = TxData[0] ^ err_in;
   end

   assign tx_in = {err_in, TxElecIdle, TxDataValid, TxDataK, data_in};

   // Tx-to-Rx delay line; the Rx output register supplies the final cycle
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         for (int unsigned s = 0; s < LOOP_LATENCY; s++) stage[s] <= STAGE_RST;
      end else begin
         stage[0] <= tx_in;
         for (int unsigned s = 1; s < LOOP_LATENCY; s++) stage[s] <= stage[s-1];
      end
   end

   assign tail    = stage[LOOP_LATENCY-1];
   assign t_data  = tail[DW-1:0];
   assign t_k     = tail[DW +: KTW];
   assign t_valid = tail[DW+KTW +: LANESNUMBER];
   assign t_idle  = tail[DW+KTW+LANESNUMBER +: LANESNUMBER];
   assign t_err   = tail[STW-1];

   always_comb begin
      lane_on    = '0;
      data_mask  = '0;
      k_mask     = '0;
      eidle      = '0;
      det_status = '0;
      for (int unsigned i = 0; i < LANESNUMBER; i++) begin
         lane_on[i] = (sh_pd == PD_P0) && LanePresent[i] && !t_idle[i];
         data_mask[i*MAXPIPEWIDTH +: MAXPIPEWIDTH] = {MAXPIPEWIDTH{lane_on[i]}};
         k_mask[i*KW +: KW] = {KW{lane_on[i]}};
         eidle[i] = t_idle[i] || !LanePresent[i] || (sh_pd != PD_P0);
         det_status[i*3 +: 3] = LanePresent[i] ? 3'b011 : 3'b000;
      end
   end

   // Control FSM: reset hold, receiver detect and PowerDown/Rate change handshakes
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         state     <= RST_HOLD;
         hold_cnt  <= 1'b0;
         fire      <= 1'b0;
         cnt       <= '0;
         sh_rate   <= '0;
         sh_pd     <= '0;
         tgt_rate  <= '0;
         tgt_pd    <= '0;
         PhyStatus <= '1;
      end else begin
         PhyStatus <= '0;
         case (state)
            RST_HOLD: begin
               PhyStatus <= '1;
               if (hold_cnt) begin
                  state     <= IDLE;
                  PhyStatus <= '0;
                  sh_rate   <= Rate;
                  sh_pd     <= PowerDown[3:0];
               end else begin
                  hold_cnt <= 1'b1;
               end
            end
            IDLE: begin
               if (det_req) begin
                  state <= DETECT;
                  cnt   <= CW'(DETECT_DELAY - 1);
               end else if (chg_req) begin
                  state    <= CHANGE;
                  cnt      <= CW'(CHANGE_DELAY - 1);
                  tgt_rate <= Rate;
                  tgt_pd   <= PowerDown[3:0];
               end
            end
            DETECT: begin
               if (cnt == '0) begin
                  state <= DET_DONE;
                  fire  <= 1'b1;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            DET_DONE: begin
               if (fire) begin
                  PhyStatus <= '1;
                  fire      <= 1'b0;
               end else if (!(|TxDetectRx_Loopback)) begin
                  state <= IDLE;
               end
            end
            CHANGE: begin
               if (fire) begin
                  PhyStatus <= '1;
                  fire      <= 1'b0;
                  sh_rate   <= tgt_rate;
                  sh_pd     <= tgt_pd;
                  state     <= IDLE;
               end else if (cnt == '0) begin
                  fire <= 1'b1;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            default: state <= RST_HOLD;
         endcase
      end
   end

   // Rx output register: gating, electrical idle and status
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         RxData           <= '0;
         RxDataK          <= '0;
         RxDataValid      <= '0;
         RxValid          <= '0;
         RxElectricalIdle <= '1;
         RxStatus         <= '0;
      end else if (state == RST_HOLD) begin
         RxData           <= '0;
         RxDataK          <= '0;
         RxDataValid      <= '0;
         RxValid          <= '0;
         RxElectricalIdle <= '1;
         RxStatus         <= '0;
      end else begin
         RxData           <= t_data & data_mask;
         RxDataK          <= t_k & k_mask;
         RxDataValid      <= t_valid & lane_on;
         RxValid          <= t_valid & lane_on;
         RxElectricalIdle <= eidle;
         if (state == DET_DONE && fire)
            RxStatus <= det_status;
         else if (t_err && state != DET_DONE)
            RxStatus <= {{(3*LANESNUMBER-3){1'b0}}, 3'b100};
         else
            RxStatus <= '0;
      end
   end

endmodule

// File: tb/tb_pipe_phy_loopback_model.sv
// Directed self-checking bench for pipe_phy_loopback_model (default parameters).
module tb_pipe_phy_loopback_model;

   localparam int unsigned L   = 16;
   localparam int unsigned W   = 32;
   localparam int unsigned DW  = L * W;
   localparam int unsigned KTW = L * (W / 8);

   logic           CLK = 1'b0;
   logic           reset;
   logic [DW-1:0]  TxData;
   logic [KTW-1:0] TxDataK;
   logic [L-1:0]   TxDataValid, TxElecIdle, TxDetectRx_Loopback, LanePresent;
   logic [4*L-1:0] PowerDown;
   logic [3:0]     Rate;
`ifdef PIPE_PHY_ERR_INJECT_EN
   logic           ErrInject;
`endif
   logic [DW-1:0]  RxData;
   logic [KTW-1:0] RxDataK;
   logic [L-1:0]   RxDataValid, RxValid, RxElectricalIdle, PhyStatus;
   logic [3*L-1:0] RxStatus;

   int total  = 0;
   int passed = 0;

   always #5 CLK = ~CLK;

   pipe_phy_loopback_model dut (
      .CLK                 (CLK),
      .reset               (reset),
      .TxData              (TxData),
      .TxDataK             (TxDataK),
      .TxDataValid         (TxDataValid),
      .TxElecIdle          (TxElecIdle),
      .TxDetectRx_Loopback (TxDetectRx_Loopback),
      .PowerDown           (PowerDown),
      .Rate                (Rate),
      .LanePresent         (LanePresent),
`ifdef PIPE_PHY_ERR_INJECT_EN
      .ErrInject           (ErrInject),
`endif
      .RxData              (RxData),
      .RxDataK             (RxDataK),
      .RxDataValid         (RxDataValid),
      .RxValid             (RxValid),
      .RxElectricalIdle    (RxElectricalIdle),
      .RxStatus            (RxStatus),
      .PhyStatus           (PhyStatus)
   );

   function automatic logic [DW-1:0] pat(input int j);
      logic [DW-1:0] r;
      for (int l = 0; l < int'(L); l++) r[l*W +: W] = 32'h5A00_0000 ^ (32'(j) << 8) ^ 32'(l);
      return r;
   endfunction

   task automatic test_reset();
      reset = 1'b1;
      TxData = '0; TxDataK = '0; TxDataValid = '0; TxElecIdle = '1;
      TxDetectRx_Loopback = '0; LanePresent = 16'h00FF;
      PowerDown = {L{4'b0010}}; Rate = 4'd0;
`ifdef PIPE_PHY_ERR_INJECT_EN
      ErrInject = 1'b0;
`endif
      repeat (2) @(negedge CLK);
      total++; if (PhyStatus !== 16'hFFFF) $display("FAIL rst_phystatus got %h want ffff", PhyStatus); else passed++;
      total++; if (RxElectricalIdle !== 16'hFFFF) $display("FAIL rst_eidle got %h want ffff", RxElectricalIdle); else passed++;
      total++; if (RxStatus !== '0) $display("FAIL rst_rxstatus got %h want 0", RxStatus); else passed++;
      total++; if (RxData !== '0) $display("FAIL rst_rxdata got %h want 0", RxData); else passed++;
      reset = 1'b0;
      @(negedge CLK);
      total++; if (PhyStatus !== 16'hFFFF) $display("FAIL rel_edge1_phystatus got %h want ffff", PhyStatus); else passed++;
      @(negedge CLK);
      total++; if (PhyStatus !== 16'h0000) $display("FAIL rel_edge2_phystatus got %h want 0000", PhyStatus); else passed++;
      @(negedge CLK);
      total++; if (RxElectricalIdle !== 16'hFFFF) $display("FAIL rel_p1_eidle got %h want ffff", RxElectricalIdle); else passed++;
      total++; if (RxValid !== 16'h0000) $display("FAIL rel_rxvalid got %h want 0000", RxValid); else passed++;
   endtask

   task automatic test_detect();
      @(negedge CLK);
      TxDetectRx_Loopback = 16'hFFFF;
      for (int k = 1; k <= 6; k++) begin
         @(negedge CLK);
         total++;
         if (PhyStatus !== ((k == 6) ? 16'hFFFF : 16'h0000))
            $display("FAIL det_phystatus k=%0d got %h want %h", k, PhyStatus, (k == 6) ? 16'hFFFF : 16'h0000);
         else passed++;
      end
      total++; if (RxStatus !== 48'h0000_006D_B6DB) $display("FAIL det_rxstatus got %h want 00000006db6db", RxStatus); else passed++;
      for (int k = 0; k < 10; k++) begin
         @(negedge CLK);
         total++; if (PhyStatus !== 16'h0000) $display("FAIL det_held_phystatus k=%0d got %h want 0000", k, PhyStatus); else passed++;
         total++; if (RxStatus !== '0) $display("FAIL det_held_rxstatus k=%0d got %h want 0", k, RxStatus); else passed++;
      end
      TxDetectRx_Loopback = '0;
      repeat (3) @(negedge CLK);
   endtask

   task automatic test_loopback();
      logic [DW-1:0] hd [12];
      logic          hi3 [12];
      logic [DW-1:0] exp_d;
      logic [KTW-1:0] exp_k;
      logic [L-1:0]  exp_v, exp_e;
      PowerDown = '0; TxElecIdle = '0; LanePresent = 16'hFFFF; TxDataValid = 16'hFFFF;
      repeat (8) @(negedge CLK);
      for (int k = 0; k < 12; k++) begin
         @(negedge CLK);
         if (k >= 3) begin
            exp_d = hd[k-3];
            exp_k = {L{4'(k-3)}};
            exp_v = 16'hFFFF;
            exp_e = 16'h0000;
            if (hi3[k-3]) begin
               exp_d[3*W +: W] = '0;
               exp_k[3*4 +: 4] = '0;
               exp_v = 16'hFFF7;
               exp_e = 16'h0008;
            end
            total++; if (RxData !== exp_d) $display("FAIL loop_rxdata k=%0d got %h want %h", k, RxData, exp_d); else passed++;
            total++; if (RxDataK !== exp_k) $display("FAIL loop_rxdatak k=%0d got %h want %h", k, RxDataK, exp_k); else passed++;
            total++; if (RxValid !== exp_v) $display("FAIL loop_rxvalid k=%0d got %h want %h", k, RxValid, exp_v); else passed++;
            total++; if (RxElectricalIdle !== exp_e) $display("FAIL loop_eidle k=%0d got %h want %h", k, RxElectricalIdle, exp_e); else passed++;
         end
         hd[k]   = pat(k);
         hi3[k]  = (k >= 5);
         TxData  = hd[k];
         TxDataK = {L{4'(k)}};
         TxElecIdle[3] = hi3[k];
      end
      TxElecIdle = '0;
      repeat (3) @(negedge CLK);
   endtask

   task automatic test_rate_change();
      @(negedge CLK);
      Rate = 4'd1;
      for (int k = 1; k <= 7; k++) begin
         @(negedge CLK);
         total++;
         if (PhyStatus !== ((k == 5) ? 16'hFFFF : 16'h0000))
            $display("FAIL rate_phystatus k=%0d got %h want %h", k, PhyStatus, (k == 5) ? 16'hFFFF : 16'h0000);
         else passed++;
      end
   endtask

   task automatic test_priority();
      PowerDown = {L{4'b0010}}; TxElecIdle = '1;
      repeat (8) @(negedge CLK);
      @(negedge CLK);
      PowerDown = '0;
      TxDetectRx_Loopback = 16'hFFFF;
      for (int k = 1; k <= 14; k++) begin
         @(negedge CLK);
         total++;
         if (PhyStatus !== ((k == 6 || k == 12) ? 16'hFFFF : 16'h0000))
            $display("FAIL prio_phystatus k=%0d got %h want %h", k, PhyStatus, (k == 6 || k == 12) ? 16'hFFFF : 16'h0000);
         else passed++;
         if (k == 6) begin
            total++; if (RxStatus !== 48'h6DB6_DB6D_B6DB) $display("FAIL prio_det_rxstatus got %h want 6db6db6db6db", RxStatus); else passed++;
            TxDetectRx_Loopback = '0;
         end
      end
   endtask

   task automatic test_reset_mid_detect();
      PowerDown = {L{4'b0010}};
      repeat (8) @(negedge CLK);
      @(negedge CLK);
      TxDetectRx_Loopback = 16'hFFFF;
      repeat (3) @(negedge CLK);
      reset = 1'b1;
      TxDetectRx_Loopback = '0;
      #1;
      total++; if (PhyStatus !== 16'hFFFF) $display("FAIL middet_phystatus got %h want ffff", PhyStatus); else passed++;
      total++; if (RxElectricalIdle !== 16'hFFFF) $display("FAIL middet_eidle got %h want ffff", RxElectricalIdle); else passed++;
      total++; if (RxStatus !== '0) $display("FAIL middet_rxstatus got %h want 0", RxStatus); else passed++;
      repeat (2) @(negedge CLK);
      reset = 1'b0;
      for (int k = 0; k < 12; k++) begin
         @(negedge CLK);
         total++; if (RxStatus !== '0) $display("FAIL middet_after_rxstatus k=%0d got %h want 0", k, RxStatus); else passed++;
      end
      total++; if (PhyStatus !== 16'h0000) $display("FAIL middet_after_phystatus got %h want 0000", PhyStatus); else passed++;
   endtask

`ifdef PIPE_PHY_ERR_INJECT_EN
   task automatic test_err_inject();
      logic [DW-1:0] c;
      logic [DW-1:0] exp_d;
      c = {L{32'h8765_4320}};
      PowerDown = '0; TxElecIdle = '0; LanePresent = 16'hFFFF; TxDataValid = 16'hFFFF; TxData = c;
      repeat (8) @(negedge CLK);
      @(negedge CLK);
      ErrInject = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         @(negedge CLK);
         ErrInject = 1'b0;
         exp_d = c;
         if (k == 3) exp_d[0] = 1'b1;
         total++; if (RxData !== exp_d) $display("FAIL err_rxdata k=%0d got %h want %h", k, RxData, exp_d); else passed++;
         total++;
         if (RxStatus !== ((k == 3) ? 48'h4 : 48'h0))
            $display("FAIL err_rxstatus k=%0d got %h want %h", k, RxStatus, (k == 3) ? 48'h4 : 48'h0);
         else passed++;
      end
   endtask
`endif

   initial begin
      test_reset();
      test_detect();
      test_loopback();
      test_rate_change();
      test_priority();
      test_reset_mid_detect();
`ifdef PIPE_PHY_ERR_INJECT_EN
      test_err_inject();
`endif
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired passed=%0d total=%0d", passed, total);
      $fatal(1, "timeout");
   end

endmodule
